ram_program_loader: RTL and testbench

Hardware replacement for the bench-driven "program mode then run mode" sequence of the 4-bit CPU. The block accepts a program image as a valid/ready word stream and writes it into the CPU's RAM. It optionally verifies the load by read-back checksum, then flips the RAM mux to run mode and releases the CPU's reset after a fixed hold. It is parametrised in data width, RAM depth and hold length, and it supports reprogramming from run mode and error reporting, neither of which the manual sequence provides.

---
 rtl/ram_program_loader.sv | 145 ++++++++++++++
 tb/tb_ram_program_loader.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_program_loader.sv
// ram_program_loader
// ------------------
// Streams a program image into the CPU RAM, optionally verifies it with a
// read-back checksum, then switches the RAM mux to run mode and releases
// the CPU reset after a fixed hold period. The load can be restarted from
// RUN or FAIL.
//
// Ports:
//   Clock, Reset      rising-edge clock, synchronous active-low reset
//   Start, Len        one-cycle load request and word count (sampled with Start)
//   InData/InValid/InReady   image word stream (valid/ready)
//   RamAddr/RamData/RamWe    RAM programming port (write is combinational on a beat)
//   RamQ              RAM read data, combinational from RamAddr
//   RunSel            RAM mux select: 0 = programming, 1 = run
//   CpuReset          active-high CPU core reset
//   Busy/Done/Error   status: LOAD/VERIFY/HOLD, RUN, FAIL
//   Checksum          sum of loaded words mod 2^DATA_W
module ram_program_loader #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 4,
    parameter int HOLD_CYCLES = 2,
    parameter int VERIFY      = 1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic [ADDR_W:0]   Len,
    input  logic [DATA_W-1:0] InData,
    input  logic              InValid,
    output logic              InReady,
    output logic [ADDR_W-1:0] RamAddr,
    output logic [DATA_W-1:0] RamData,
    output logic              RamWe,
    input  logic [DATA_W-1:0] RamQ,
    output logic              RunSel,
    output logic              CpuReset,
    output logic              Busy,
    output logic              Done,
    output logic              Error,
    output logic [DATA_W-1:0] Checksum
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_VERIFY,
        S_HOLD,
        S_RUN,
        S_FAIL
    } state_t;

    state_t            state;
    logic [ADDR_W:0]   counter;
    logic [ADDR_W:0]   len_reg;
    logic [DATA_W-1:0] checksum;
    logic [DATA_W-1:0] rb_sum;
    logic [HW-1:0]     hold_cnt;

    logic              beat;
    logic              start_ok;
    logic              at_last;
    logic [ADDR_W:0]   len_clamped;
    logic [DATA_W-1:0] rb_sum_now;

    assign beat        = InValid && (state == S_LOAD);
    // Start is only honoured when nothing is in flight, and Len = 0 means "no load".
    assign start_ok    = Start && (Len != '0) &&
                         ((state == S_IDLE) || (state == S_RUN) || (state == S_FAIL));
    assign len_clamped = (Len > DEPTH_V) ? DEPTH_V : Len;
    assign at_last     = (counter == (len_reg - (ADDR_W + 1)'(1)));
    // The final verify cycle compares against the sum including its own RamQ.
    assign rb_sum_now  = rb_sum + RamQ;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state    <= S_IDLE;
            counter  <= '0;
            len_reg  <= '0;
            checksum <= '0;
            rb_sum   <= '0;
            hold_cnt <= '0;
        end else begin
            case (state)
                S_IDLE, S_RUN, S_FAIL: begin
                    if (start_ok) begin
                        state    <= S_LOAD;
                        counter  <= '0;
                        checksum <= '0;
                        len_reg  <= len_clamped;
                    end
                end
                S_LOAD: begin
                    if (beat) begin
                        checksum <= checksum + InData;
                        if (at_last) begin
                            counter  <= '0;
                            rb_sum   <= '0;
                            hold_cnt <= '0;
                            state    <= (VERIFY != 0) ? S_VERIFY : S_HOLD;
                        end else begin
                            counter <= counter + (ADDR_W + 1)'(1);
                        end
                    end
                end
                S_VERIFY: begin
                    rb_sum <= rb_sum_now;
                    if (at_last) begin
                        counter <= '0;
                        state   <= (rb_sum_now == checksum) ? S_HOLD : S_FAIL;
                    end else begin
                        counter <= counter + (ADDR_W + 1)'(1);
                    end
                end
                S_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_cnt <= '0;
                        state    <= S_RUN;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Outputs are pure decodes of registered state, except the RAM write
    // strobe/data which follow the handshake within the beat cycle.
    assign InReady  = (state == S_LOAD);
    assign RamWe    = beat;
    assign RamData  = beat ? InData : '0;
    assign RamAddr  = ((state == S_LOAD) || (state == S_VERIFY)) ? counter[ADDR_W-1:0] : '0;
    assign RunSel   = (state == S_HOLD) || (state == S_RUN);
    assign CpuReset = (state != S_RUN);
    assign Busy     = (state == S_LOAD) || (state == S_VERIFY) || (state == S_HOLD);
    assign Done     = (state == S_RUN);
    assign Error    = (state == S_FAIL);
    assign Checksum = checksum;

endmodule

// File: tb/tb_ram_program_loader.sv
// Directed testbench for ram_program_loader with a behavioural RAM that can
// corrupt the word written to address 5.
module tb_ram_program_loader;

    logic       Clock = 0;
    logic       Reset, Start, InValid;
    logic [4:0] Len;
    logic [7:0] InData, RamData, RamQ, Checksum;
    logic [3:0] RamAddr;
    logic       InReady, RamWe, RunSel, CpuReset, Busy, Done, Error;

    ram_program_loader #(.DATA_W(8), .ADDR_W(4), .HOLD_CYCLES(2), .VERIFY(1)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Len(Len),
        .InData(InData), .InValid(InValid), .InReady(InReady),
        .RamAddr(RamAddr), .RamData(RamData), .RamWe(RamWe), .RamQ(RamQ),
        .RunSel(RunSel), .CpuReset(CpuReset), .Busy(Busy), .Done(Done),
        .Error(Error), .Checksum(Checksum)
    );

    always #5 Clock = ~Clock;

    logic [7:0] ram [16];
    logic [7:0] img [16];
    bit         corrupt = 0;
    int         wr_cnt = 0;
    logic [3:0] last_addr = '0;

    always @(posedge Clock) begin
        if (RamWe) begin
            ram[RamAddr] <= (corrupt && RamAddr == 4'd5) ? RamData - 8'd1 : RamData;
            wr_cnt       <= wr_cnt + 1;
            last_addr    <= RamAddr;
        end
    end
    assign RamQ = ram[RamAddr];

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_start(input logic [4:0] len);
        Start = 1; Len = len;
        step();
        Start = 0; Len = '0;
    endtask

    // Feeds n image words; when stall is set InValid is low on every third cycle.
    task automatic feed(input int n, input bit stall, output int cycles);
        int idx;
        idx = 0;
        cycles = 0;
        while (idx < n && cycles < 100) begin
            if (stall && (cycles % 3 == 2)) InValid = 0;
            else begin
                InValid = 1;
                InData  = img[idx % 16];
            end
            #1;
            if (!InValid) check("no_write_on_stall", 32'(RamWe), 0);
            else if (InReady) begin
                check("beat_we", 32'(RamWe), 1);
                check("beat_addr", 32'(RamAddr), 32'(idx % 16));
                idx++;
            end
            step();
            cycles++;
        end
        InValid = 0;
        check("feed_beats", 32'(idx), 32'(n));
    endtask

    task automatic wait_runsel(output int w);
        w = 0;
        while (!RunSel && !Error && w < 100) begin
            step();
            w++;
        end
    endtask

    initial begin
        int c, w, w0;
        img = '{8'hBF, 8'h0E, 8'hE0, 8'hBD, 8'h8D, 8'hBF, 8'h0E, 8'hE0,
                8'hBD, 8'h8F, 8'hBE, 8'hAC, 8'h04, 8'h00, 8'h01, 8'h01};
        Reset = 0; Start = 0; Len = '0; InValid = 0; InData = '0;
        step(); step();
        check("rst_inready", 32'(InReady), 0);
        check("rst_ramwe", 32'(RamWe), 0);
        check("rst_ramaddr", 32'(RamAddr), 0);
        check("rst_ramdata", 32'(RamData), 0);
        check("rst_runsel", 32'(RunSel), 0);
        check("rst_cpureset", 32'(CpuReset), 1);
        check("rst_busy", 32'(Busy), 0);
        check("rst_done", 32'(Done), 0);
        check("rst_error", 32'(Error), 0);
        check("rst_checksum", 32'(Checksum), 0);
        $display("reset: outputs checked");
        Reset = 1;
        step();

        do_start(5'd0);
        check("len0_inready", 32'(InReady), 0);
        check("len0_busy", 32'(Busy), 0);
        $display("start len=0: ignored");

        // Fibonacci image, no stalls
        w0 = wr_cnt;
        do_start(5'd16);
        feed(16, 0, c);
        check("fib_load_cycles", 32'(c), 16);
        wait_runsel(w);
        check("fib_hold_after", 32'(c + w), 32);
        check("fib_hold1_runsel", 32'(RunSel), 1);
        check("fib_hold1_cpureset", 32'(CpuReset), 1);
        check("fib_checksum", 32'(Checksum), 32'h60);
        step();
        check("fib_hold2_runsel", 32'(RunSel), 1);
        check("fib_hold2_cpureset", 32'(CpuReset), 1);
        step();
        check("fib_run_cpureset", 32'(CpuReset), 0);
        check("fib_run_done", 32'(Done), 1);
        check("fib_writes", 32'(wr_cnt - w0), 16);
        check("fib_last_addr", 32'(last_addr), 15);
        check("fib_ram5", 32'(ram[5]), 32'hBF);
        $display("fibonacci load: run reached, checksum %0h", Checksum);

        // Same image with a stall every third cycle, started from RUN
        w0 = wr_cnt;
        do_start(5'd16);
        check("stall_start_runsel", 32'(RunSel), 0);
        check("stall_start_cpureset", 32'(CpuReset), 1);
        feed(16, 1, c);
        check("stall_load_cycles", 32'(c), 23);
        wait_runsel(w);
        check("stall_verify_cycles", 32'(w), 16);
        step(); step();
        check("stall_done", 32'(Done), 1);
        check("stall_checksum", 32'(Checksum), 32'h60);
        check("stall_writes", 32'(wr_cnt - w0), 16);
        check("stall_ram15", 32'(ram[15]), 32'h01);
        $display("stalled load: run reached, checksum %0h", Checksum);

        // Corrupting RAM -> FAIL, then retry with a good RAM
        corrupt = 1;
        do_start(5'd16);
        feed(16, 0, c);
        wait_runsel(w);
        check("bad_verify_cycles", 32'(w), 16);
        check("bad_error", 32'(Error), 1);
        check("bad_runsel", 32'(RunSel), 0);
        check("bad_cpureset", 32'(CpuReset), 1);
        check("bad_busy", 32'(Busy), 0);
        check("bad_checksum", 32'(Checksum), 32'h60);
        step();
        check("bad_error_hold", 32'(Error), 1);
        $display("corrupt RAM: fail state reached");
        corrupt = 0;
        do_start(5'd16);
        check("retry_error_clr", 32'(Error), 0);
        feed(16, 0, c);
        wait_runsel(w);
        step(); step();
        check("retry_done", 32'(Done), 1);
        check("retry_error", 32'(Error), 0);
        $display("retry: run reached");

        // Len = 20 clamps to 16
        w0 = wr_cnt;
        do_start(5'd20);
        feed(16, 0, c);
        InValid = 1; InData = 8'h55;
        #1;
        check("clamp_inready17", 32'(InReady), 0);
        check("clamp_we17", 32'(RamWe), 0);
        InValid = 0;
        check("clamp_writes", 32'(wr_cnt - w0), 16);
        check("clamp_last_addr", 32'(last_addr), 15);
        wait_runsel(w);
        step(); step();
        check("clamp_done", 32'(Done), 1);
        $display("len=20: clamped to 16 words");

        // Reload of 3 words from RUN
        w0 = wr_cnt;
        do_start(5'd3);
        check("len3_runsel", 32'(RunSel), 0);
        check("len3_cpureset", 32'(CpuReset), 1);
        feed(3, 0, c);
        wait_runsel(w);
        check("len3_verify_cycles", 32'(w), 3);
        check("len3_checksum", 32'(Checksum), 32'hAD);
        step(); step();
        check("len3_done", 32'(Done), 1);
        check("len3_writes", 32'(wr_cnt - w0), 3);
        check("len3_last_addr", 32'(last_addr), 2);
        $display("len=3 reload: run reached, checksum %0h", Checksum);

        // Start during HOLD is ignored
        do_start(5'd3);
        feed(3, 0, c);
        wait_runsel(w);
        Start = 1; Len = 5'd3;
        step();
        Start = 0; Len = '0;
        check("hold_start_runsel", 32'(RunSel), 1);
        check("hold_start_cpureset", 32'(CpuReset), 1);
        check("hold_start_inready", 32'(InReady), 0);
        step();
        check("hold_start_done", 32'(Done), 1);
        $display("start in hold: ignored");

        // Reset during the 7th load beat
        do_start(5'd16);
        feed(6, 0, c);
        InValid = 1; InData = img[6]; Reset = 0;
        step();
        Reset = 1; InValid = 0;
        check("midrst_inready", 32'(InReady), 0);
        check("midrst_cpureset", 32'(CpuReset), 1);
        check("midrst_checksum", 32'(Checksum), 0);
        check("midrst_busy", 32'(Busy), 0);
        check("midrst_runsel", 32'(RunSel), 0);
        step();
        check("midrst_idle", 32'(InReady), 0);
        $display("reset mid-load: idle");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
